// File: rtl/trace_pkg.sv
// Shared definitions for the bus trace UART: character constants, the
// transmitter state encoding and the nibble-to-ASCII helper.
package trace_pkg;

    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;
    localparam int         FRAME_CHARS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A start presented while ready is high during the final
// stop-bit cycle chains the next byte with no idle gap on the line.
module uart_tx_byte
    import trace_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q,  baud_d;
    logic [3:0]  bit_q,   bit_d;
    logic [9:0]  shift_q, shift_d;
    logic        tick;

    assign tick  = (baud_q == BAUD_MAX);
    assign ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    assign busy  = (state_q != ST_IDLE);
    // The line is the LSB of the frame register, so it never glitches.
    assign tx    = shift_q[0];

    // NOTE: every registered signal sits on the async reset, so an abort mid-frame returns the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: all next-state values take their hold default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_START;
                shift_d = {1'b1, data, 1'b0};
                baud_d  = '0;
                bit_d   = '0;
            end
        end else if (!tick) begin
            baud_d = baud_q + 16'd1;
        end else begin
            baud_d  = '0;
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
            unique case (state_q)
                ST_START: state_d = ST_DATA;
                ST_DATA:  if (bit_q == 4'd8) state_d = ST_STOP;
                ST_STOP: begin
                    bit_d = '0;
                    if (start) begin
                        state_d = ST_START;
                        shift_d = {1'b1, data, 1'b0};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bus_trace_uart.sv
// Snapshots the CPU bus on a trigger (or on change) and prints it over UART as
// eight hex digits plus CR LF; one pending slot absorbs triggers during a frame.
module bus_trace_uart
    import trace_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 434,
    parameter bit          SEND_ON_CHANGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus,
    input  logic        trig,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    logic        trig_q;
    logic [31:0] prev_bus_q;
    logic [31:0] pending_q,       pending_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] snapshot_q,      snapshot_d;
    logic [3:0]  char_idx_q,      char_idx_d;
    logic [7:0]  drop_cnt_q,      drop_cnt_d;

    logic        trig_evt;
    logic        load;
    logic        chain;
    logic [31:0] load_word;
    logic        u_start;
    logic [7:0]  u_data;
    logic        u_ready;
    logic        u_busy;

    function automatic logic [7:0] char_at(input logic [31:0] word, input logic [3:0] idx);
        logic [31:0] shifted;
        shifted = word << {idx[2:0], 2'b00};
        if (idx < 4'd8) begin
            return hex2ascii(shifted[31:28]);
        end
        return (idx == 4'd8) ? CHAR_CR : CHAR_LF;
    endfunction

    assign trig_evt  = (trig && !trig_q) || (SEND_ON_CHANGE && (bus != prev_bus_q));
    assign load      = !u_busy && (pending_valid_q || trig_evt);
    assign load_word = pending_valid_q ? pending_q : bus;
    assign chain     = u_busy && u_ready && (char_idx_q != 4'(FRAME_CHARS - 1));
    assign u_start   = load || chain;
    assign u_data    = load ? char_at(load_word, 4'd0) : char_at(snapshot_q, char_idx_q + 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q          <= 1'b0;
            prev_bus_q      <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            snapshot_q      <= '0;
            char_idx_q      <= '0;
            drop_cnt_q      <= '0;
        end else begin
            trig_q          <= trig;
            prev_bus_q      <= bus;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            snapshot_q      <= snapshot_d;
            char_idx_q      <= char_idx_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        snapshot_d      = snapshot_q;
        char_idx_d      = char_idx_q;
        drop_cnt_d      = drop_cnt_q;

        if (load) begin
            snapshot_d = load_word;
            char_idx_d = '0;
        end else if (chain) begin
            char_idx_d = char_idx_q + 4'd1;
        end

        // A waiting snapshot always wins the idle slot; a coincident trigger refills it.
        if (!u_busy) begin
            if (pending_valid_q) begin
                pending_valid_d = trig_evt;
                if (trig_evt) pending_d = bus;
            end
        end else if (trig_evt) begin
            pending_d       = bus;
            pending_valid_d = 1'b1;
            if (pending_valid_q && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (u_start),
        .data  (u_data),
        .ready (u_ready),
        .tx    (tx),
        .busy  (u_busy)
    );

    assign busy     = u_busy;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_trace_uart.sv
// Directed bench: two instances (trigger-only and change mode), a UART decoder
// per line, and a byte scoreboard filled when each trace is requested.
module tb_bus_trace_uart;

    localparam int DIV = 4;
    localparam int MID = DIV / 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus, bus2;
    logic        trig, trig2;
    logic        tx, busy, tx2, busy2;
    logic [7:0]  drop_cnt, drop_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         rx_cnt[2];
    int         rx_expect[2];
    bit         mon_active[2];
    int         mon_cnt[2];
    logic [7:0] mon_byte[2];
    logic       mon_line;
    logic [8:0] mon_exp;

    always #5 clk = ~clk;

    bus_trace_uart #(.CLK_DIV(DIV), .SEND_ON_CHANGE(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus), .trig(trig),
        .tx(tx), .busy(busy), .drop_cnt(drop_cnt)
    );

    bus_trace_uart #(.CLK_DIV(DIV), .SEND_ON_CHANGE(1'b1)) dut_chg (
        .clk(clk), .reset(reset), .bus(bus2), .trig(trig2),
        .tx(tx2), .busy(busy2), .drop_cnt(drop_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_chars(input int which, input logic [31:0] w, input int count);
        logic [7:0] c;
        for (int i = 0; i < count; i++) begin
            if (i < 8) c = hex_char(w[31-4*i -: 4]);
            else if (i == 8) c = 8'h0D;
            else c = 8'h0A;
            if (which == 0) exp_q0.push_back(c);
            else exp_q1.push_back(c);
            rx_expect[which]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
    endtask

    task automatic wait_busy(input int which, input logic level, input int budget, input string tag);
        int n;
        n = 0;
        while (((which == 0) ? busy : busy2) !== level && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'((which == 0) ? busy : busy2), 32'(level));
    endtask

    task automatic check_drained(input int which, input string tag);
        check({tag, "_queue"}, 32'((which == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
        check({tag, "_rxcnt"}, 32'(rx_cnt[which]), 32'(rx_expect[which]));
    endtask

    // UART decoder sampling mid-bit on the falling clock edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mon_line = (k == 0) ? tx : tx2;
            if (reset) begin
                mon_active[k] = 1'b0;
            end else if (!mon_active[k]) begin
                if (mon_line === 1'b0) begin
                    mon_active[k] = 1'b1;
                    mon_cnt[k]    = 0;
                    mon_byte[k]   = 8'h00;
                end
            end else begin
                mon_cnt[k]++;
                if (mon_cnt[k] >= MID + DIV && mon_cnt[k] <= MID + 8*DIV && ((mon_cnt[k] - MID) % DIV) == 0) begin
                    mon_byte[k] = {mon_line, mon_byte[k][7:1]};
                end else if (mon_cnt[k] == MID + 9*DIV) begin
                    check($sformatf("stop_bit_line%0d", k), 32'(mon_line), 32'd1);
                    if (k == 0) mon_exp = (exp_q0.size() > 0) ? {1'b0, exp_q0.pop_front()} : 9'h1FF;
                    else        mon_exp = (exp_q1.size() > 0) ? {1'b0, exp_q1.pop_front()} : 9'h1FF;
                    check($sformatf("rx_byte_line%0d_n%0d", k, rx_cnt[k]), 32'(mon_byte[k]), 32'(mon_exp));
                    rx_cnt[k]++;
                    mon_active[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus   = '0;
        bus2  = '0;
        trig  = 1'b0;
        trig2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx",    32'(tx),       32'd1);
        check("reset_busy",  32'(busy),     32'd0);
        check("reset_drop",  32'(drop_cnt), 32'd0);
        check("reset_tx2",   32'(tx2),      32'd1);
        check("reset_busy2", 32'(busy2),    32'd0);
        reset = 1'b0;
        step();
        step();

        // Single trace and exact busy length.
        bus = 32'h1234ABCD;
        push_chars(0, bus, 10);
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        check("single_busy_cycles", 32'(n), 32'd400);
        check("single_tx_idle", 32'(tx), 32'd1);
        check_drained(0, "single");

        // Back-to-back frames with one idle cycle between.
        bus = 32'h0F1E2D3C;
        push_chars(0, bus, 10);
        pulse_trig();
        bus = 32'hDEADBEEF;
        push_chars(0, bus, 10);
        pulse_trig();
        wait_busy(0, 1'b0, 500, "b2b_first_end");
        check("b2b_gap_tx", 32'(tx), 32'd1);
        step();
        check("b2b_one_idle", 32'(busy), 32'd1);
        wait_busy(0, 1'b0, 500, "b2b_second_end");
        check("b2b_drop", 32'(drop_cnt), 32'd0);
        check_drained(0, "b2b");

        // Overflow: second pending write replaces the first.
        bus = 32'hCAFEF00D;
        push_chars(0, bus, 10);
        pulse_trig();
        bus = 32'h00000001;
        pulse_trig();
        bus = 32'h00000002;
        push_chars(0, bus, 10);
        pulse_trig();
        check("ovf_drop_now", 32'(drop_cnt), 32'd1);
        wait_busy(0, 1'b0, 500, "ovf_first_end");
        step();
        wait_busy(0, 1'b0, 500, "ovf_second_end");
        check("ovf_drop_final", 32'(drop_cnt), 32'd1);
        check_drained(0, "ovf");

        // Change mode on the second instance.
        bus2 = 32'h0000FFFF;
        push_chars(1, bus2, 10);
        wait_busy(1, 1'b1, 10, "chg_start");
        wait_busy(1, 1'b0, 500, "chg_end");
        n = 0;
        repeat (300) begin
            step();
            if (busy2 !== 1'b0) n++;
        end
        check("chg_no_repeat", 32'(n), 32'd0);
        check_drained(1, "chg");

        // Reset during the fourth character.
        bus = 32'h55AA0F0F;
        push_chars(0, bus, 3);
        pulse_trig();
        repeat (128) step();
        reset = 1'b1;
        bus2  = '0;
        #1;
        check("rst_mid_tx",   32'(tx),       32'd1);
        check("rst_mid_busy", 32'(busy),     32'd0);
        check("rst_mid_drop", 32'(drop_cnt), 32'd0);
        step();
        step();
        reset = 1'b0;
        n = 0;
        repeat (60) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        check("rst_quiet", 32'(n), 32'd0);
        check_drained(0, "rst");
        bus = 32'h89ABCDEF;
        push_chars(0, bus, 10);
        pulse_trig();
        wait_busy(0, 1'b0, 500, "rst_after_end");
        check_drained(0, "rst_after");

        // Saturation: two bursts of 150 triggers across two frames.
        bus = 32'h00C0FFEE;
        push_chars(0, bus, 10);
        pulse_trig();
        bus = 32'h0BADF00D;
        push_chars(0, bus, 10);
        repeat (150) pulse_trig();
        check("sat_drop_149", 32'(drop_cnt), 32'd149);
        wait_busy(0, 1'b0, 500, "sat_a_end");
        wait_busy(0, 1'b1, 5, "sat_b_start");
        bus = 32'h600DCAFE;
        push_chars(0, bus, 10);
        repeat (150) pulse_trig();
        check("sat_drop_255", 32'(drop_cnt), 32'd255);
        wait_busy(0, 1'b0, 500, "sat_b_end");
        wait_busy(0, 1'b1, 5, "sat_c_start");
        wait_busy(0, 1'b0, 500, "sat_c_end");
        check("sat_drop_hold", 32'(drop_cnt), 32'd255);
        check_drained(0, "sat");
        check_drained(1, "final_chg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
